fast_square_seq: RTL and testbench
==================================

# fast_square_seq

Sweep sequencer directly upstream of `fast_square_rx`. It produces the `record` window and `freq_step` pulse that drive the receiver's subcarrier accumulators and subcarrier frequency stepping. For each frequency step it runs a programmable settle gap, then a fixed-length record window, then a one-clock step pulse. Its step count and run mode are programmed over the standard serial settings bus.

## Interface
Parameters:
- SETTLEADDR, 3, settings address of settle length in clocks (bits [15:0]).
- NUMSTEPSADDR, 4, settings address of steps per sweep (bits [7:0]).
- CTRLADDR, 5, settings address of control: bit0 run, bit1 continuous.
- RECORD_TICKS_LOG2, 14, record window length is 2^RECORD_TICKS_LOG2 clocks; must match the receiver.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset; asynchronous, active-high.
- serial_addr  in  7  settings bus address.
- serial_data  in  32  settings bus data.
- serial_strobe  in  1  settings bus write strobe.
- record  out  1  receiver accumulate enable.
- freq_step  out  1  one-clock pulse that latches sums and advances the subcarrier frequency.
- step_index  out  8  index of the step currently settling or recording.
- sweep_done  out  1  one-clock pulse coincident with the last step's freq_step.
- busy  out  1  high in every state except IDLE.

## Operation
- Settings registers are decoded internally. On the clock edge where serial_strobe is high and serial_addr matches, the register loads serial_data. All three reset asynchronously to 0.
- States and transitions:
  - IDLE: record=0, busy=0. Enters SETTLE when run=1.
  - SETTLE: record=0. Counts settle_len clocks, then enters RECORD. If settle_len=0, goes to RECORD on the next clock.
  - RECORD: record=1 for exactly 2^RECORD_TICKS_LOG2 clocks, then enters STEP.
  - STEP: lasts one clock; freq_step=1, record=0.
    - If step_index == num_steps_latched-1: sweep_done=1 and step_index returns to 0. Then SETTLE if continuous=1, else IDLE.
    - Otherwise step_index increments and the next state is SETTLE.
- settle_len and num_steps are latched on each IDLE->SETTLE transition and on each sweep wrap. Writes during a sweep take effect at the next sweep. num_steps=0 is treated as 1.
- Abort: run=0 seen in SETTLE or RECORD moves the block to IDLE on the next clock. No freq_step or sweep_done is issued, and step_index clears to 0.
  - A run=0 seen in STEP does not suppress that STEP's pulse; the block then goes to IDLE.
- Clearing run while continuous=1 ends the sweep at the same boundary rules.
- record and freq_step are never high in the same cycle. The receiver gives freq_step priority, but the sequencer guarantees mutual exclusion anyway.
- Counters: settle counter is 16-bit. Record counter is RECORD_TICKS_LOG2+1 bits, so it does not wrap before terminal count.

## Timing
- All outputs are registered.
- Reset values: record=0, freq_step=0, sweep_done=0, busy=0, step_index=0; state IDLE; all counters 0.
- A reset assertion mid-sweep forces the reset values immediately, without waiting for a clock edge.
- Start latency: with the CTRL write (run=1) on edge N, busy and SETTLE begin at edge N+1.
  - With settle_len=S, record rises at edge N+1+S.
  - record falls at edge N+1+S+2^RECORD_TICKS_LOG2.
  - freq_step is high for that one cycle only.
- Step period is S + 2^RECORD_TICKS_LOG2 + 1 clocks.
- step_index changes on the same edge that freq_step falls, i.e. on entry to the next SETTLE or IDLE.
- A simultaneous settings write and state transition: the transition uses the pre-write values; the latch rules above apply.

## Structure
- Shared package holds:
  - state encoding: IDLE=2'd0, SETTLE=2'd1, RECORD=2'd2, STEP=2'd3;
  - CTRL bit positions: RUN_BIT=0, CONT_BIT=1;
  - the settings-address defaults, so the receiver and sequencer addresses stay consistent.
- One natural sub-module, `fs_setting_reg_ar`: a settings register with asynchronous reset, instantiated three times.
- The FSM and counters stay in the top module.

## Test plan
All scenarios use RECORD_TICKS_LOG2=4.
- Reset: assert reset mid-RECORD -> record, freq_step, busy drop in the same cycle as reset; step_index=0.
- Single sweep: settle=3, num_steps=2, CTRL=1 -> two windows with record high 16 clocks each, separated by 3 low clocks; freq_step after each window; sweep_done with the second freq_step; busy falls; step_index ends at 0.
- Zero settle / zero steps: settle=0, num_steps=0, CTRL=1 -> record rises one clock after busy; exactly one window and one freq_step with sweep_done; then IDLE.
- Continuous: num_steps=3, CTRL=3 -> step_index cycles 0,1,2,0; sweep_done every third freq_step; 20-clock step period with settle=3.
- Abort: clear run at record clock 8 -> record low on the next clock, no freq_step, IDLE, step_index=0.
- Mid-sweep write: num_steps changes 2->5 during step 0 -> the current sweep still ends after 2 steps; the next sweep uses 5.

Source files
------------

// File: rtl/fast_square_seq_pkg.sv
// Shared definitions for the fast_square sweep sequencer and its receiver.
// Holds the FSM state encoding, CTRL register bit positions, the default
// settings-bus addresses (so receiver and sequencer stay consistent) and
// the settings-bus widths.
package fast_square_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RECORD = 2'd2,
        STEP   = 2'd3
    } seq_state_t;

    localparam int RUN_BIT  = 0;
    localparam int CONT_BIT = 1;

    localparam int SETTLE_ADDR_DEFAULT   = 3;
    localparam int NUMSTEPS_ADDR_DEFAULT = 4;
    localparam int CTRL_ADDR_DEFAULT     = 5;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int SETTLE_W   = 16;
    localparam int NUMSTEPS_W = 8;
    localparam int CTRL_W     = 2;

    // A programmed step count of zero still runs a single step.
    function automatic logic [NUMSTEPS_W-1:0] eff_steps(input logic [NUMSTEPS_W-1:0] n);
        return (n == '0) ? NUMSTEPS_W'(1) : n;
    endfunction

endpackage

// File: rtl/fast_square_seq_if.sv
// Serial settings bus shared by the fast_square blocks.
//   serial_addr   : register address
//   serial_data   : write data
//   serial_strobe : write strobe, one clock per write
// master drives the bus, slave (a settings decoder) only listens.
interface fast_square_seq_if;
    import fast_square_seq_pkg::*;

    logic [ADDR_W-1:0] serial_addr;
    logic [DATA_W-1:0] serial_data;
    logic              serial_strobe;

    modport master (output serial_addr, output serial_data, output serial_strobe);
    modport slave  (input  serial_addr, input  serial_data, input  serial_strobe);
endinterface

// File: rtl/fast_square_seq_setting_reg_ar.sv
// Settings register with asynchronous active-high reset.
//   clock, reset : clock and async reset (value clears to 0)
//   strobe, addr : settings-bus write strobe and address
//   data_in      : low WIDTH bits of the settings-bus data
//   value        : current register contents
// Loads data_in on any clock edge where strobe is high and addr == ADDR.
module fs_setting_reg_ar #(
    parameter int ADDR  = 0,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [6:0]       addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] value
);
    localparam logic [6:0] ADDR_BITS = 7'(ADDR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (strobe && (addr == ADDR_BITS)) begin
            value <= data_in;
        end
    end
endmodule

// File: rtl/fast_square_seq.sv
// Sweep sequencer feeding fast_square_rx. Each frequency step runs a
// programmable settle gap, a 2^RECORD_TICKS_LOG2-clock record window and a
// one-clock freq_step pulse; sweep_done marks the last step of a sweep.
//   clock, reset : system clock, async active-high reset
//   bus          : serial settings bus (settle length, steps, control)
//   record       : receiver accumulate enable
//   freq_step    : latch sums / advance subcarrier, one clock
//   step_index   : step currently settling or recording
//   sweep_done   : pulse coincident with the last step's freq_step
//   busy         : high whenever not IDLE
// All outputs are registered.
module fast_square_seq
    import fast_square_seq_pkg::*;
#(
    parameter int SETTLEADDR        = SETTLE_ADDR_DEFAULT,
    parameter int NUMSTEPSADDR      = NUMSTEPS_ADDR_DEFAULT,
    parameter int CTRLADDR          = CTRL_ADDR_DEFAULT,
    parameter int RECORD_TICKS_LOG2 = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    fast_square_seq_if.slave      bus,
    output logic                  record,
    output logic                  freq_step,
    output logic [NUMSTEPS_W-1:0] step_index,
    output logic                  sweep_done,
    output logic                  busy
);
    // One extra bit keeps the record counter from wrapping before terminal count.
    localparam logic [RECORD_TICKS_LOG2:0] REC_LAST = {1'b0, {RECORD_TICKS_LOG2{1'b1}}};

    logic [SETTLE_W-1:0]   settle_len;
    logic [NUMSTEPS_W-1:0] num_steps;
    logic [CTRL_W-1:0]     ctrl;

    fs_setting_reg_ar #(.ADDR(SETTLEADDR), .WIDTH(SETTLE_W)) settle_reg (
        .clock   (clock),
        .reset   (reset),
        .strobe  (bus.serial_strobe),
        .addr    (bus.serial_addr),
        .data_in (bus.serial_data[SETTLE_W-1:0]),
        .value   (settle_len)
    );

    fs_setting_reg_ar #(.ADDR(NUMSTEPSADDR), .WIDTH(NUMSTEPS_W)) num_steps_reg (
        .clock   (clock),
        .reset   (reset),
        .strobe  (bus.serial_strobe),
        .addr    (bus.serial_addr),
        .data_in (bus.serial_data[NUMSTEPS_W-1:0]),
        .value   (num_steps)
    );

    fs_setting_reg_ar #(.ADDR(CTRLADDR), .WIDTH(CTRL_W)) ctrl_reg (
        .clock   (clock),
        .reset   (reset),
        .strobe  (bus.serial_strobe),
        .addr    (bus.serial_addr),
        .data_in (bus.serial_data[CTRL_W-1:0]),
        .value   (ctrl)
    );

    seq_state_t                 state;
    logic [SETTLE_W-1:0]        settle_len_lat;
    logic [NUMSTEPS_W-1:0]      num_steps_lat;
    logic [SETTLE_W-1:0]        settle_cnt;
    logic [RECORD_TICKS_LOG2:0] rec_cnt;

    logic run;
    logic cont;
    logic settle_done;
    logic last_step;

    assign run  = ctrl[RUN_BIT];
    assign cont = ctrl[CONT_BIT];
    // A zero settle length still spends one clock in SETTLE.
    assign settle_done = (settle_len_lat == '0) || (settle_cnt == settle_len_lat - SETTLE_W'(1));
    assign last_step   = (step_index == num_steps_lat - NUMSTEPS_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            record         <= 1'b0;
            freq_step      <= 1'b0;
            sweep_done     <= 1'b0;
            busy           <= 1'b0;
            step_index     <= '0;
            settle_len_lat <= '0;
            num_steps_lat  <= '0;
            settle_cnt     <= '0;
            rec_cnt        <= '0;
        end else begin
            freq_step  <= 1'b0;
            sweep_done <= 1'b0;
            case (state)
                IDLE: begin
                    record     <= 1'b0;
                    busy       <= 1'b0;
                    step_index <= '0;
                    if (run) begin
                        state          <= SETTLE;
                        busy           <= 1'b1;
                        settle_len_lat <= settle_len;
                        num_steps_lat  <= eff_steps(num_steps);
                        settle_cnt     <= '0;
                    end
                end
                SETTLE: begin
                    if (!run) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        step_index <= '0;
                        settle_cnt <= '0;
                    end else if (settle_done) begin
                        state   <= RECORD;
                        record  <= 1'b1;
                        rec_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                RECORD: begin
                    if (!run) begin
                        state      <= IDLE;
                        record     <= 1'b0;
                        busy       <= 1'b0;
                        step_index <= '0;
                        rec_cnt    <= '0;
                    end else if (rec_cnt == REC_LAST) begin
                        state      <= STEP;
                        record     <= 1'b0;
                        freq_step  <= 1'b1;
                        sweep_done <= last_step;
                    end else begin
                        rec_cnt <= rec_cnt + 1'b1;
                    end
                end
                STEP: begin
                    settle_cnt <= '0;
                    // The pulse already went out; run=0 here only stops what follows.
                    if (!run) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        step_index <= '0;
                    end else if (last_step) begin
                        step_index <= '0;
                        if (cont) begin
                            state          <= SETTLE;
                            settle_len_lat <= settle_len;
                            num_steps_lat  <= eff_steps(num_steps);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state      <= SETTLE;
                        step_index <= step_index + NUMSTEPS_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fast_square_seq.sv
module tb_fast_square_seq;
    localparam int L       = 4;
    localparam int REC_LEN = 16;
    localparam logic [6:0] A_SETTLE = 7'd3;
    localparam logic [6:0] A_NSTEPS = 7'd4;
    localparam logic [6:0] A_CTRL   = 7'd5;

    logic       clock = 1'b0;
    logic       reset;
    logic       record, freq_step, sweep_done, busy;
    logic [7:0] step_index;

    fast_square_seq_if bus ();

    fast_square_seq #(
        .SETTLEADDR(3), .NUMSTEPSADDR(4), .CTRLADDR(5), .RECORD_TICKS_LOG2(L)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .record     (record),
        .freq_step  (freq_step),
        .step_index (step_index),
        .sweep_done (sweep_done),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int idx;
        int done;
        int rec_len;
        int gap;
    } ev_t;

    typedef struct {
        int settle;
        int nsteps;
        int mid;     // num_steps rewritten during step 0; -1 = no rewrite
        int ctrl;
        int total;   // freq_step pulses to wait for before clearing run
    } vec_t;

    ev_t  exp_q[$];
    vec_t vt[5];
    int   vectors = 0;
    int   miscompares = 0;
    int   gap_cnt = 0;
    int   rec_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Scoreboard side: measure each settle gap and record window, pop the
    // expected step record on every freq_step.
    always @(negedge clock) begin
        if (reset || !busy) begin
            gap_cnt = 0;
            rec_cnt = 0;
        end else if (freq_step) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_freq_step: step_index %0d, no step pending", step_index);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                $display("step idx=%0d done=%0d rec=%0d gap=%0d", step_index, sweep_done, rec_cnt, gap_cnt);
                check("step_index", 32'(step_index), 32'(e.idx));
                check("sweep_done", 32'(sweep_done), 32'(e.done));
                check("record_len", 32'(rec_cnt), 32'(e.rec_len));
                check("settle_gap", 32'(gap_cnt), 32'(e.gap));
                check("record_during_step", 32'(record), 32'd0);
            end
            gap_cnt = 0;
            rec_cnt = 0;
        end else if (record) begin
            rec_cnt++;
        end else begin
            gap_cnt++;
            check("sweep_done_outside_step", 32'(sweep_done), 32'd0);
        end
    end

    task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
        bus.serial_addr   = a;
        bus.serial_data   = d;
        bus.serial_strobe = 1'b1;
        @(negedge clock);
        bus.serial_strobe = 1'b0;
    endtask

    task automatic wait_freq_step(output bit ok);
        int t;
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (!freq_step && t < 400);
        ok = freq_step;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL freq_step_timeout: got no pulse in %0d clocks, required one", t);
        end
    endtask

    function automatic int eff(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    task automatic push_model(input vec_t v);
        int cur_n, idx;
        ev_t e;
        cur_n = eff(v.nsteps);
        idx = 0;
        for (int k = 0; k < v.total; k++) begin
            e.idx     = idx;
            e.done    = (idx == cur_n - 1) ? 1 : 0;
            e.rec_len = REC_LEN;
            e.gap     = (v.settle == 0) ? 1 : v.settle;
            exp_q.push_back(e);
            if (idx == cur_n - 1) begin
                idx = 0;
                if (v.mid >= 0) cur_n = eff(v.mid);
            end else begin
                idx++;
            end
        end
    endtask

    task automatic wait_record(output int t);
        t = 0;
        while (!record && t < 100) begin
            @(negedge clock);
            t++;
        end
    endtask

    initial begin
        bit ok;
        int t;

        vt[0] = '{settle: 3, nsteps: 2, mid: -1, ctrl: 1, total: 2};  // single sweep
        vt[1] = '{settle: 0, nsteps: 0, mid: -1, ctrl: 1, total: 1};  // zero settle / zero steps
        vt[2] = '{settle: 3, nsteps: 3, mid: -1, ctrl: 3, total: 6};  // continuous
        vt[3] = '{settle: 3, nsteps: 2, mid: 5,  ctrl: 3, total: 7};  // mid-sweep rewrite
        vt[4] = '{settle: 7, nsteps: 1, mid: -1, ctrl: 1, total: 1};

        reset = 1'b1;
        bus.serial_addr   = '0;
        bus.serial_data   = '0;
        bus.serial_strobe = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_record", 32'(record), 32'd0);
        check("reset_freq_step", 32'(freq_step), 32'd0);
        check("reset_sweep_done", 32'(sweep_done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_step_index", 32'(step_index), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int v = 0; v < 5; v++) begin
            $display("vector %0d: settle=%0d steps=%0d ctrl=%0d", v, vt[v].settle, vt[v].nsteps, vt[v].ctrl);
            bus_write(A_SETTLE, 32'(vt[v].settle));
            bus_write(A_NSTEPS, 32'(vt[v].nsteps));
            push_model(vt[v]);
            bus_write(A_CTRL, 32'(vt[v].ctrl));
            if (vt[v].mid >= 0) begin
                repeat (4) @(negedge clock);
                bus_write(A_NSTEPS, 32'(vt[v].mid));
            end
            for (int k = 0; k < vt[v].total; k++) begin
                wait_freq_step(ok);
                if (!ok) begin
                    bus_write(A_CTRL, 32'd0);
                    exp_q.delete();
                    break;
                end
                // Clear run on the final STEP clock so no further sweep starts.
                if (k == vt[v].total - 1) bus_write(A_CTRL, 32'd0);
            end
            repeat (3) @(negedge clock);
            check("end_busy", 32'(busy), 32'd0);
            check("end_record", 32'(record), 32'd0);
            check("end_step_index", 32'(step_index), 32'd0);
            check("end_pending_steps", 32'(exp_q.size()), 32'd0);
        end

        // Abort in the middle of a record window.
        $display("abort sequence");
        bus_write(A_SETTLE, 32'd3);
        bus_write(A_NSTEPS, 32'd2);
        bus_write(A_CTRL, 32'd1);
        wait_record(t);
        check("abort_record_rise", 32'(record), 32'd1);
        repeat (7) @(negedge clock);
        bus_write(A_CTRL, 32'd0);
        check("abort_record_still_high", 32'(record), 32'd1);
        @(negedge clock);
        check("abort_record", 32'(record), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_step_index", 32'(step_index), 32'd0);
        check("abort_freq_step", 32'(freq_step), 32'd0);
        repeat (40) @(negedge clock);
        check("abort_stays_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a record window.
        $display("reset sequence");
        bus_write(A_SETTLE, 32'd3);
        bus_write(A_NSTEPS, 32'd2);
        bus_write(A_CTRL, 32'd1);
        wait_record(t);
        repeat (4) @(negedge clock);
        check("pre_reset_record", 32'(record), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_record", 32'(record), 32'd0);
        check("async_reset_freq_step", 32'(freq_step), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_step_index", 32'(step_index), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("post_reset_idle", 32'(busy), 32'd0);
        check("post_reset_pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
